jelly_rtos_task_tmo: RTL and testbench

//  Per-task control block for the Jelly hardware RTOS, next generation of the single-task state holder.

---
 rtl/jelly_rtos_pkg.sv | 31 +++
 rtl/jelly_rtos_timer.sv | 48 ++++
 rtl/jelly_rtos_task_tmo.sv | 191 +++++++++++++++++++
 tb/tb_jelly_rtos_task_tmo.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jelly_rtos_pkg.sv
// Shared types for the Jelly hardware RTOS task control blocks.
package jelly_rtos_pkg;

  typedef enum logic [2:0] {
    TS_SLEEP  = 3'd0,
    TS_REQRDY = 3'd1,
    TS_READY  = 3'd2,
    TS_DELAY  = 3'd3,
    TS_WAISEM = 3'd4,
    TS_WAIFLG = 3'd5
  } tskstat_t;

  typedef enum logic [1:0] {
    E_OK    = 2'd0,
    E_TMOUT = 2'd1,
    E_RLWAI = 2'd2
  } ercd_t;

  typedef enum logic {
    WF_AND = 1'b0,
    WF_OR  = 1'b1
  } wfmode_t;

  // Polling timeout value; the forever timeout is all-ones at whatever width is used.
  localparam int TMO_POL = 0;

  function automatic logic is_wait(input tskstat_t s);
    return (s == TS_SLEEP) || (s == TS_DELAY) || (s == TS_WAISEM) || (s == TS_WAIFLG);
  endfunction

endpackage

// File: rtl/jelly_rtos_timer.sv
// Wait/delay down-counter: load, hold-forever on all-ones, frozen when cke is low.
// Resets into the forever state so a task sleeping from reset never times out.
module jelly_rtos_timer
  import jelly_rtos_pkg::*;
#(
  parameter int RELTIM_WIDTH = 32
) (
  input  logic                    reset_n,
  input  logic                    clk,
  input  logic                    cke,
  input  logic                    load,
  input  logic [RELTIM_WIDTH-1:0] load_val,
  input  logic                    run,
  output logic                    zero
);

  logic [RELTIM_WIDTH-1:0] cnt_q, cnt_d;
  logic                    fevr_q, fevr_d;

  always_comb begin
    cnt_d  = cnt_q;
    fevr_d = fevr_q;
    if (load) begin
      cnt_d  = load_val;
      fevr_d = &load_val;
    end else if (run) begin
      if (!fevr_q && (cnt_q != RELTIM_WIDTH'(TMO_POL))) begin
        cnt_d = cnt_q - RELTIM_WIDTH'(1);
      end
    end else begin
      cnt_d  = '0;
      fevr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      fevr_q <= 1'b1;
    end else if (cke) begin
      cnt_q  <= cnt_d;
      fevr_q <= fevr_d;
    end
  end

  assign zero = !fevr_q && (cnt_q == RELTIM_WIDTH'(TMO_POL));

endmodule

// File: rtl/jelly_rtos_task_tmo.sv
// Per-task control block: wait states with timeout, queued wakeups, release reasons, priority change.
// One instance per task ID; ops are filtered by op_tskid, arbiter strobes override ops.
module jelly_rtos_task_tmo
  import jelly_rtos_pkg::*;
#(
  parameter int TSKID_WIDTH  = 4,
  parameter int TSKPRI_WIDTH = 4,
  parameter int FLGPTN_WIDTH = 4,
  parameter int RELTIM_WIDTH = 32,
  parameter int WUPCNT_WIDTH = 2,
  parameter int TSKID        = 0,
  parameter int INIT_TSKPRI  = TSKID
) (
  input  logic                    reset_n,
  input  logic                    clk,
  input  logic                    cke,
  output logic                    busy,
  output logic                    req_rdq,
  output logic [2:0]              tskstat,
  output logic [TSKPRI_WIDTH-1:0] tskpri,
  output logic [WUPCNT_WIDTH-1:0] wupcnt,
  output logic [1:0]              ercd,
  input  logic                    rdy_tsk,
  input  logic                    rel_tsk,
  input  logic [FLGPTN_WIDTH-1:0] flgptn,
  input  logic [TSKID_WIDTH-1:0]  op_tskid,
  input  logic [RELTIM_WIDTH-1:0] op_tmout,
  input  logic [RELTIM_WIDTH-1:0] op_dlytim,
  input  logic                    wup_tsk_valid,
  input  logic                    slp_tsk_valid,
  input  logic                    dly_tsk_valid,
  input  logic                    rel_wai_valid,
  input  logic                    can_wup_valid,
  input  logic                    wai_sem_valid,
  input  logic                    wai_flg_valid,
  input  logic                    wai_flg_wfmode,
  input  logic [FLGPTN_WIDTH-1:0] wai_flg_flgptn,
  input  logic                    chg_pri_valid,
  input  logic [TSKPRI_WIDTH-1:0] chg_pri_tskpri
);

  tskstat_t                stat_q, stat_d;
  ercd_t                   ercd_q, ercd_d;
  wfmode_t                 wfmode_q, wfmode_d;
  logic [FLGPTN_WIDTH-1:0] wptn_q, wptn_d;
  logic [TSKPRI_WIDTH-1:0] tskpri_q, tskpri_d;
  logic [WUPCNT_WIDTH-1:0] wupcnt_q, wupcnt_d;
  logic                    req_rdq_q, req_rdq_d;

  logic                    op_hit, op_chg, op_load, op_latch;
  tskstat_t                op_stat;
  ercd_t                   op_ercd;
  logic [RELTIM_WIDTH-1:0] op_val;
  logic                    flg_match;
  logic                    tmr_load, tmr_run, tmr_zero;
  logic [RELTIM_WIDTH-1:0] tmr_val;

  assign flg_match = (wfmode_q == WF_AND) ? &(flgptn | ~wptn_q) : |(flgptn & wptn_q);

  // Op decode yields a candidate transition; arbiter strobes and internal releases are merged below.
  always_comb begin
    op_hit   = (op_tskid == TSKID_WIDTH'(TSKID));
    op_chg   = 1'b0;
    op_stat  = stat_q;
    op_ercd  = ercd_q;
    op_load  = 1'b0;
    op_val   = op_tmout;
    op_latch = 1'b0;
    wupcnt_d = wupcnt_q;
    tskpri_d = tskpri_q;
    if (op_hit) begin
      if (wup_tsk_valid) begin
        if (stat_q == TS_SLEEP) begin
          op_chg  = 1'b1;
          op_stat = TS_REQRDY;
          op_ercd = E_OK;
        end else if (wupcnt_q != '1) begin
          wupcnt_d = wupcnt_q + 1'b1;
        end
      end else if (slp_tsk_valid) begin
        if (wupcnt_q != '0) begin
          wupcnt_d = wupcnt_q - 1'b1;
        end else begin
          op_chg  = 1'b1;
          op_stat = TS_SLEEP;
          op_ercd = E_OK;
          op_load = 1'b1;
        end
      end else if (dly_tsk_valid) begin
        op_chg  = 1'b1;
        op_stat = TS_DELAY;
        op_ercd = E_OK;
        op_load = 1'b1;
        op_val  = op_dlytim;
      end else if (rel_wai_valid) begin
        if (is_wait(stat_q)) begin
          op_chg  = 1'b1;
          op_stat = TS_REQRDY;
          op_ercd = E_RLWAI;
        end
      end else if (wai_sem_valid) begin
        op_chg  = 1'b1;
        op_stat = TS_WAISEM;
        op_ercd = E_OK;
        op_load = 1'b1;
      end else if (wai_flg_valid) begin
        op_chg   = 1'b1;
        op_stat  = TS_WAIFLG;
        op_ercd  = E_OK;
        op_load  = 1'b1;
        op_latch = 1'b1;
      end else if (can_wup_valid) begin
        wupcnt_d = '0;
      end
      if (chg_pri_valid) begin
        tskpri_d = chg_pri_tskpri;
      end
    end

    stat_d   = stat_q;
    ercd_d   = ercd_q;
    wfmode_d = wfmode_q;
    wptn_d   = wptn_q;
    tmr_load = 1'b0;
    tmr_val  = op_val;
    if (rdy_tsk) begin
      stat_d = TS_READY;
    end else if (rel_tsk) begin
      stat_d = TS_REQRDY;
    end else if (op_chg) begin
      stat_d   = op_stat;
      ercd_d   = op_ercd;
      tmr_load = op_load;
      if (op_latch) begin
        wfmode_d = wfmode_t'(wai_flg_wfmode);
        wptn_d   = wai_flg_flgptn;
      end
    end else if ((stat_q == TS_WAIFLG) && flg_match) begin
      stat_d = TS_REQRDY;
      ercd_d = E_OK;
    end else if (is_wait(stat_q) && tmr_zero) begin
      stat_d = TS_REQRDY;
      ercd_d = (stat_q == TS_DELAY) ? E_OK : E_TMOUT;
    end
  end

  always_comb begin
    busy      = (stat_d == TS_REQRDY);
    req_rdq_d = busy;
    req_rdq   = req_rdq_q;
    tskstat   = stat_q;
    tskpri    = tskpri_q;
    wupcnt    = wupcnt_q;
    ercd      = ercd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_q    <= TS_SLEEP;
      ercd_q    <= E_OK;
      wfmode_q  <= WF_AND;
      wptn_q    <= '0;
      tskpri_q  <= TSKPRI_WIDTH'(INIT_TSKPRI);
      wupcnt_q  <= '0;
      req_rdq_q <= 1'b0;
    end else if (cke) begin
      stat_q    <= stat_d;
      ercd_q    <= ercd_d;
      wfmode_q  <= wfmode_d;
      wptn_q    <= wptn_d;
      tskpri_q  <= tskpri_d;
      wupcnt_q  <= wupcnt_d;
      req_rdq_q <= req_rdq_d;
    end
  end

  assign tmr_run = is_wait(stat_d);

  jelly_rtos_timer #(
    .RELTIM_WIDTH(RELTIM_WIDTH)
  ) u_timer (
    .reset_n  (reset_n),
    .clk      (clk),
    .cke      (cke),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .zero     (tmr_zero)
  );

endmodule

// File: tb/tb_jelly_rtos_task_tmo.sv
// Directed bench for jelly_rtos_task_tmo: vector table plus multi-cycle timeout/flag/reset sequences.
module tb_jelly_rtos_task_tmo;

  localparam int OP_NONE = 0, OP_WUP = 1, OP_SLP = 2, OP_DLY = 3, OP_REL = 4,
                 OP_SEM = 5, OP_FLG = 6, OP_CAN = 7;
  localparam logic [2:0] S_SLEEP = 3'd0, S_REQRDY = 3'd1, S_READY = 3'd2,
                         S_DELAY = 3'd3, S_WAISEM = 3'd4, S_WAIFLG = 3'd5;
  localparam logic [31:0] FEVR = 32'hFFFF_FFFF;

  logic        reset_n, clk, cke;
  logic        busy, req_rdq;
  logic [2:0]  tskstat;
  logic [3:0]  tskpri;
  logic [1:0]  wupcnt, ercd;
  logic        rdy_tsk, rel_tsk;
  logic [3:0]  flgptn, op_tskid;
  logic [31:0] op_tmout, op_dlytim;
  logic        wup_tsk_valid, slp_tsk_valid, dly_tsk_valid, rel_wai_valid, can_wup_valid;
  logic        wai_sem_valid, wai_flg_valid, wai_flg_wfmode;
  logic [3:0]  wai_flg_flgptn;
  logic        chg_pri_valid;
  logic [3:0]  chg_pri_tskpri;

  int checks = 0;
  int errors = 0;

  jelly_rtos_task_tmo #(
    .TSKID_WIDTH(4), .TSKPRI_WIDTH(4), .FLGPTN_WIDTH(4), .RELTIM_WIDTH(32),
    .WUPCNT_WIDTH(2), .TSKID(3), .INIT_TSKPRI(9)
  ) dut (
    .reset_n(reset_n), .clk(clk), .cke(cke), .busy(busy), .req_rdq(req_rdq),
    .tskstat(tskstat), .tskpri(tskpri), .wupcnt(wupcnt), .ercd(ercd),
    .rdy_tsk(rdy_tsk), .rel_tsk(rel_tsk), .flgptn(flgptn), .op_tskid(op_tskid),
    .op_tmout(op_tmout), .op_dlytim(op_dlytim),
    .wup_tsk_valid(wup_tsk_valid), .slp_tsk_valid(slp_tsk_valid),
    .dly_tsk_valid(dly_tsk_valid), .rel_wai_valid(rel_wai_valid),
    .can_wup_valid(can_wup_valid), .wai_sem_valid(wai_sem_valid),
    .wai_flg_valid(wai_flg_valid), .wai_flg_wfmode(wai_flg_wfmode),
    .wai_flg_flgptn(wai_flg_flgptn), .chg_pri_valid(chg_pri_valid),
    .chg_pri_tskpri(chg_pri_tskpri)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [3:0]  tid;
    logic [31:0] tmo;
    logic        rdy;
    logic        rel;
    logic        chg;
    logic [3:0]  pri;
    logic        e_busy;
    logic [2:0]  e_stat;
    logic [1:0]  e_wup;
    logic [1:0]  e_ercd;
    logic [3:0]  e_pri;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    wup_tsk_valid = 1'b0; slp_tsk_valid = 1'b0; dly_tsk_valid = 1'b0;
    rel_wai_valid = 1'b0; can_wup_valid = 1'b0; wai_sem_valid = 1'b0;
    wai_flg_valid = 1'b0; chg_pri_valid = 1'b0; rdy_tsk = 1'b0; rel_tsk = 1'b0;
  endtask

  task automatic drive_op(input int op, input logic [3:0] tid, input logic [31:0] tmo);
    op_tskid      = tid;
    op_tmout      = tmo;
    op_dlytim     = tmo;
    wup_tsk_valid = (op == OP_WUP);
    slp_tsk_valid = (op == OP_SLP);
    dly_tsk_valid = (op == OP_DLY);
    rel_wai_valid = (op == OP_REL);
    wai_sem_valid = (op == OP_SEM);
    wai_flg_valid = (op == OP_FLG);
    can_wup_valid = (op == OP_CAN);
  endtask

  task automatic do_op(input int op, input logic [31:0] tmo);
    drive_op(op, 4'd3, tmo);
    step();
    clear_ops();
  endtask

  // Counts edges until req_rdq rises, bounded.
  task automatic wait_req(input string name, input int exp_k);
    int k;
    k = 0;
    while (!req_rdq && k < 200) begin
      step();
      k++;
    end
    chk(name, k, exp_k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0]  = '{OP_WUP,  4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, S_REQRDY, 2'd0, 2'd0, 4'd9};
    vecs[1]  = '{OP_NONE, 4'd3, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd0, 2'd0, 4'd9};
    vecs[2]  = '{OP_WUP,  4'd5, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd0, 2'd0, 4'd9};
    vecs[3]  = '{OP_WUP,  4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd1, 2'd0, 4'd9};
    vecs[4]  = '{OP_WUP,  4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd2, 2'd0, 4'd9};
    vecs[5]  = '{OP_WUP,  4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd3, 2'd0, 4'd9};
    vecs[6]  = '{OP_WUP,  4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd3, 2'd0, 4'd9};
    vecs[7]  = '{OP_SLP,  4'd3, FEVR,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd2, 2'd0, 4'd9};
    vecs[8]  = '{OP_SLP,  4'd3, FEVR,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd1, 2'd0, 4'd9};
    vecs[9]  = '{OP_SLP,  4'd3, FEVR,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd0, 2'd0, 4'd9};
    vecs[10] = '{OP_SLP,  4'd3, FEVR,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_SLEEP,  2'd0, 2'd0, 4'd9};
    vecs[11] = '{OP_NONE, 4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_SLEEP,  2'd0, 2'd0, 4'd9};
    vecs[12] = '{OP_REL,  4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, S_REQRDY, 2'd0, 2'd2, 4'd9};
    vecs[13] = '{OP_WUP,  4'd3, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd1, 2'd2, 4'd9};
    vecs[14] = '{OP_CAN,  4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd0, 2'd2, 4'd9};
    vecs[15] = '{OP_REL,  4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd0, 2'd2, 4'd9};
    vecs[16] = '{OP_NONE, 4'd3, 32'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, S_READY,  2'd0, 2'd2, 4'd4};
    vecs[17] = '{OP_SEM,  4'd3, FEVR,  1'b0, 1'b0, 1'b1, 4'd7, 1'b0, S_WAISEM, 2'd0, 2'd0, 4'd7};
    vecs[18] = '{OP_NONE, 4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_WAISEM, 2'd0, 2'd0, 4'd7};
    vecs[19] = '{OP_SLP,  4'd5, FEVR,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, S_WAISEM, 2'd0, 2'd0, 4'd7};
    vecs[20] = '{OP_REL,  4'd3, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, S_REQRDY, 2'd0, 2'd2, 4'd7};
    vecs[21] = '{OP_NONE, 4'd3, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd0, 2'd2, 4'd7};
    vecs[22] = '{OP_NONE, 4'd3, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, S_REQRDY, 2'd0, 2'd2, 4'd7};
    vecs[23] = '{OP_NONE, 4'd3, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, S_READY,  2'd0, 2'd2, 4'd7};
    vecs[24] = '{OP_NONE, 4'd5, 32'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, S_READY,  2'd0, 2'd2, 4'd7};

    reset_n = 1'b0; cke = 1'b1; flgptn = '0; op_tskid = '0; op_tmout = '0; op_dlytim = '0;
    wai_flg_wfmode = 1'b0; wai_flg_flgptn = '0; chg_pri_tskpri = '0;
    clear_ops();
    step();
    chk("rst_stat", tskstat, S_SLEEP);
    chk("rst_rdq", req_rdq, 0);
    chk("rst_pri", tskpri, 9);
    chk("rst_wup", wupcnt, 0);
    chk("rst_ercd", ercd, 0);
    chk("rst_busy", busy, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("idle_sleep", tskstat, S_SLEEP);

    for (int i = 0; i < 25; i++) begin
      drive_op(vecs[i].op, vecs[i].tid, vecs[i].tmo);
      rdy_tsk = vecs[i].rdy;
      rel_tsk = vecs[i].rel;
      chg_pri_valid = vecs[i].chg;
      chg_pri_tskpri = vecs[i].pri;
      #1;
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      step();
      clear_ops();
      chk($sformatf("v%0d_stat", i), tskstat, vecs[i].e_stat);
      chk($sformatf("v%0d_wup", i), wupcnt, vecs[i].e_wup);
      chk($sformatf("v%0d_ercd", i), ercd, vecs[i].e_ercd);
      chk($sformatf("v%0d_pri", i), tskpri, vecs[i].e_pri);
      chk($sformatf("v%0d_rdq", i), req_rdq, vecs[i].e_busy);
    end

    do_op(OP_DLY, 32'd5);
    chk("dly_state", tskstat, S_DELAY);
    chk("dly_ercd_clr", ercd, 0);
    wait_req("dly_latency", 6);
    chk("dly_ercd", ercd, 0);
    rdy_tsk = 1'b1; step(); clear_ops();
    chk("dly_ready", tskstat, S_READY);

    do_op(OP_SEM, 32'd3);
    chk("sem3_state", tskstat, S_WAISEM);
    wait_req("sem3_latency", 4);
    chk("sem3_ercd", ercd, 1);
    rdy_tsk = 1'b1; step(); clear_ops();

    do_op(OP_SEM, 32'd0);
    chk("pol_state", tskstat, S_WAISEM);
    wait_req("pol_latency", 1);
    chk("pol_ercd", ercd, 1);
    rdy_tsk = 1'b1; step(); clear_ops();

    do_op(OP_SEM, FEVR);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (req_rdq) seen++;
    end
    chk("fevr_no_rdq", seen, 0);
    chk("fevr_state", tskstat, S_WAISEM);
    do_op(OP_REL, 32'd0);
    chk("fevr_rel_stat", tskstat, S_REQRDY);
    chk("fevr_rel_ercd", ercd, 2);
    rdy_tsk = 1'b1; step(); clear_ops();

    wai_flg_wfmode = 1'b0; wai_flg_flgptn = 4'b0110;
    do_op(OP_FLG, FEVR);
    chk("and_state", tskstat, S_WAIFLG);
    flgptn = 4'b0010;
    step(); step(); step();
    chk("and_partial", tskstat, S_WAIFLG);
    flgptn = 4'b0110;
    #1;
    chk("and_busy", busy, 1);
    step();
    chk("and_rdq", req_rdq, 1);
    chk("and_ercd", ercd, 0);
    flgptn = '0;
    rdy_tsk = 1'b1; step(); clear_ops();

    wai_flg_wfmode = 1'b1; wai_flg_flgptn = 4'b1000;
    do_op(OP_FLG, FEVR);
    step();
    chk("or_wait", tskstat, S_WAIFLG);
    flgptn = 4'b1000;
    step();
    chk("or_rdq", req_rdq, 1);
    chk("or_ercd", ercd, 0);
    flgptn = '0;
    rdy_tsk = 1'b1; step(); clear_ops();

    wai_flg_wfmode = 1'b0; wai_flg_flgptn = 4'b0001;
    do_op(OP_FLG, 32'd2);
    step(); step();
    flgptn = 4'b0001;
    #1;
    chk("tie_busy", busy, 1);
    step();
    chk("tie_ercd", ercd, 0);
    flgptn = '0;
    rdy_tsk = 1'b1; step(); clear_ops();

    do_op(OP_DLY, 32'd20);
    for (int i = 0; i < 13; i++) step();
    chk("rstmid_state_pre", tskstat, S_DELAY);
    reset_n = 1'b0;
    #1;
    chk("rstmid_stat", tskstat, S_SLEEP);
    chk("rstmid_pri", tskpri, 9);
    step(); step();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (req_rdq) seen++;
    end
    chk("rstmid_no_rdq", seen, 0);
    chk("rstmid_sleep", tskstat, S_SLEEP);

    do_op(OP_DLY, 32'd3);
    cke = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("cke_hold_stat", tskstat, S_DELAY);
    chk("cke_hold_rdq", req_rdq, 0);
    cke = 1'b1;
    wait_req("cke_latency", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
